tf_modmul_pipe: RTL and testbench

- Consumes the twiddle factor stream from the horizontal twiddle-factor block and multiplies each butterfly output sample by its twiddle.
- Arithmetic is modulo the Goldilocks prime p = 2^64 - 2^32 + 1.
- Fully pipelined, one sample per enabled cycle, gated by the shared active-low CEN.
- Tags each result with a 0..15 intra-group index and pulses frame_done on index wrap, so the next radix-16 stage can align groups.

---
 rtl/tf_modmul_pipe.sv | 230 +++++++++++++++++++++++
 tb/tb_tf_modmul_pipe.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/tf_modmul_pipe.sv
// -----------------------------------------------------------------------------
// tf_modmul_pipe
//
// Purpose:
//   Multiplies each butterfly output sample by its twiddle factor modulo the
//   Goldilocks prime p = 2^64 - 2^32 + 1. The pipeline is fully pipelined and
//   accepts one sample per enabled cycle. The whole pipe, including the valid
//   chain and the group index counter, is frozen while CEN = 1. Each result is
//   tagged with a 0..15 intra-group index, and frame_done marks the last beat
//   of every 16-sample group.
//
//   Pipeline (registers are loaded on enabled edges only):
//     s1  : register in_data, tf, in_valid
//     s2  : four 32x32 partial products
//     s3  : 128-bit product P = lo64 + m32*2^64 + h32*2^96
//     s4  : folded 64-bit value t1 (uses 2^64 = 2^32-1 and 2^96 = -1 mod p)
//     out : conditional subtract of p gives the canonical result
//   in_valid sampled at edge k appears as out_valid at edge k+4.
//
// Optional feature (macro TF_MUL_ONE_BYPASS_EN):
//   When the macro is defined, a sample whose tf == 1 skips the multiplier.
//   s1 flags it and holds the multiplier operand registers. The raw in_data
//   travels down the pipe beside the flag. The output stage then reduces
//   in_data with the same single conditional subtract of p. Latency and
//   results are identical to the multiply path.
//
// Ports:
//   clk        in   clock
//   rst_n      in   asynchronous reset, active HIGH (the historical name is
//                   kept for compatibility with the surrounding codebase)
//   CEN        in   active-low enable; 1 freezes every register
//   in_valid   in   in_data/tf pair valid this cycle
//   in_data    in   [P_WIDTH-1:0]   butterfly output sample (any value)
//   tf         in   [P_WIDTH-1:0]   twiddle factor (any value)
//   out_valid  out  out_data valid
//   out_data   out  [P_WIDTH-1:0]   (in_data * tf) mod p, canonical
//   out_idx    out  [IDX_WIDTH-1:0] index of the current output in its group
//   frame_done out  out_valid & (out_idx == all ones)
// -----------------------------------------------------------------------------
module tf_modmul_pipe #(
   parameter int P_WIDTH   = 64,
   parameter int IDX_WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 CEN,
   input  logic                 in_valid,
   input  logic [P_WIDTH-1:0]   in_data,
   input  logic [P_WIDTH-1:0]   tf,
   output logic                 out_valid,
   output logic [P_WIDTH-1:0]   out_data,
   output logic [IDX_WIDTH-1:0] out_idx,
   output logic                 frame_done
);

   localparam int H = P_WIDTH / 2;
   localparam int W = 2 * P_WIDTH;

   // p and 2^32 - 1 (= 2^64 mod p), both written as 32-bit halves.
   localparam logic [P_WIDTH-1:0] P_MOD = {{H{1'b1}}, {(H-1){1'b0}}, 1'b1};
   localparam logic [P_WIDTH-1:0] EPS   = {{H{1'b0}}, {H{1'b1}}};

   logic en;
   assign en = ~CEN;

   // ---------------- pipeline registers ----------------
   logic               v1_q, v1_d, v2_q, v2_d, v3_q, v3_d, v4_q, v4_d;
   logic [P_WIDTH-1:0] a1_q, a1_d, b1_q, b1_d;
   logic [P_WIDTH-1:0] pp_ll_q, pp_ll_d, pp_lh_q, pp_lh_d;
   logic [P_WIDTH-1:0] pp_hl_q, pp_hl_d, pp_hh_q, pp_hh_d;
   logic [W-1:0]       prod_q, prod_d;
   logic [P_WIDTH-1:0] t1_q, t1_d;
   logic               out_valid_q, out_valid_d;
   logic [P_WIDTH-1:0] out_data_q, out_data_d;
   logic [IDX_WIDTH-1:0] idx_q, idx_d;

`ifdef TF_MUL_ONE_BYPASS_EN
   logic               one1_q, one1_d, one2_q, one2_d, one3_q, one3_d, one4_q, one4_d;
   logic [P_WIDTH-1:0] raw1_q, raw1_d, raw2_q, raw2_d, raw3_q, raw3_d, raw4_q, raw4_d;
   logic               tf_is_one;
   assign tf_is_one = in_valid && (tf == {{(P_WIDTH-1){1'b0}}, 1'b1});
`endif

   // ---------------- s4 folding (combinational, feeds t1_q) ----------------
   logic [P_WIDTH-1:0] lo64;
   logic [H-1:0]       m32, h32;
   logic [P_WIDTH:0]   diff_w, sum_w;
   logic [P_WIDTH-1:0] t0, m_fold, t1_c;

   assign lo64 = prod_q[P_WIDTH-1:0];
   assign m32  = prod_q[P_WIDTH+H-1:P_WIDTH];
   assign h32  = prod_q[W-1:P_WIDTH+H];

   // h32*2^96 = -h32 (mod p). A borrow wrapped the result by +2^64, and
   // 2^64 = 2^32-1 (mod p), so 2^32-1 is taken back off. This cannot borrow
   // again because the wrapped value is at least 2^64 - 2^32 + 1.
   assign diff_w = {1'b0, lo64} - {{(H+1){1'b0}}, h32};
   assign t0     = diff_w[P_WIDTH] ? (diff_w[P_WIDTH-1:0] - EPS) : diff_w[P_WIDTH-1:0];

   // m32*2^64 = m32*(2^32-1) (mod p). The product fits in 64 bits.
   assign m_fold = {m32, {H{1'b0}}} - {{H{1'b0}}, m32};

   // A carry out dropped 2^64, so 2^32-1 is added back. The wrapped sum is
   // small enough that this add cannot carry again.
   assign sum_w = {1'b0, t0} + {1'b0, m_fold};
   assign t1_c  = sum_w[P_WIDTH] ? (sum_w[P_WIDTH-1:0] + EPS) : sum_w[P_WIDTH-1:0];

   // ---------------- output stage source ----------------
   // t1 < 2^64 < 2p, so one conditional subtract of p is enough.
   logic [P_WIDTH-1:0] red_src;
`ifdef TF_MUL_ONE_BYPASS_EN
   assign red_src = one4_q ? raw4_q : t1_q;
`else
   assign red_src = t1_q;
`endif

   // ---------------- next-state logic ----------------
   always_comb begin
      v1_d        = v1_q;
      v2_d        = v2_q;
      v3_d        = v3_q;
      v4_d        = v4_q;
      a1_d        = a1_q;
      b1_d        = b1_q;
      pp_ll_d     = pp_ll_q;
      pp_lh_d     = pp_lh_q;
      pp_hl_d     = pp_hl_q;
      pp_hh_d     = pp_hh_q;
      prod_d      = prod_q;
      t1_d        = t1_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      idx_d       = idx_q;
`ifdef TF_MUL_ONE_BYPASS_EN
      one1_d = one1_q;  one2_d = one2_q;  one3_d = one3_q;  one4_d = one4_q;
      raw1_d = raw1_q;  raw2_d = raw2_q;  raw3_d = raw3_q;  raw4_d = raw4_q;
`endif
      if (en) begin
         // s1
         v1_d = in_valid;
         a1_d = in_data;
         b1_d = tf;
`ifdef TF_MUL_ONE_BYPASS_EN
         one1_d = tf_is_one;
         raw1_d = in_data;
         // Hold the multiplier operands so they do not toggle for a bypassed sample.
         if (tf_is_one) begin
            a1_d = a1_q;
            b1_d = b1_q;
         end
         one2_d = one1_q;  raw2_d = raw1_q;
         one3_d = one2_q;  raw3_d = raw2_q;
         one4_d = one3_q;  raw4_d = raw3_q;
`endif
         // s2: 32x32 partial products
         v2_d    = v1_q;
         pp_ll_d = {{H{1'b0}}, a1_q[H-1:0]}       * {{H{1'b0}}, b1_q[H-1:0]};
         pp_lh_d = {{H{1'b0}}, a1_q[H-1:0]}       * {{H{1'b0}}, b1_q[P_WIDTH-1:H]};
         pp_hl_d = {{H{1'b0}}, a1_q[P_WIDTH-1:H]} * {{H{1'b0}}, b1_q[H-1:0]};
         pp_hh_d = {{H{1'b0}}, a1_q[P_WIDTH-1:H]} * {{H{1'b0}}, b1_q[P_WIDTH-1:H]};
         // s3: full 128-bit product (the true value cannot overflow 128 bits)
         v3_d   = v2_q;
         prod_d = {pp_hh_q, pp_ll_q}
                + {{H{1'b0}}, pp_lh_q, {H{1'b0}}}
                + {{H{1'b0}}, pp_hl_q, {H{1'b0}}};
         // s4
         v4_d = v3_q;
         t1_d = t1_c;
         // output stage
         out_valid_d = v4_q;
         out_data_d  = (red_src >= P_MOD) ? (red_src - P_MOD) : red_src;
         // The index advances when a valid beat leaves the output register, so
         // out_idx always names the sample on out_data and bubbles leave it alone.
         if (out_valid_q) begin
            idx_d = idx_q + 1'b1;
         end
      end
   end

   // ---------------- state registers ----------------
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         v1_q        <= 1'b0;
         v2_q        <= 1'b0;
         v3_q        <= 1'b0;
         v4_q        <= 1'b0;
         a1_q        <= '0;
         b1_q        <= '0;
         pp_ll_q     <= '0;
         pp_lh_q     <= '0;
         pp_hl_q     <= '0;
         pp_hh_q     <= '0;
         prod_q      <= '0;
         t1_q        <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         idx_q       <= '0;
`ifdef TF_MUL_ONE_BYPASS_EN
         one1_q <= 1'b0;  one2_q <= 1'b0;  one3_q <= 1'b0;  one4_q <= 1'b0;
         raw1_q <= '0;    raw2_q <= '0;    raw3_q <= '0;    raw4_q <= '0;
`endif
      end else begin
         v1_q        <= v1_d;
         v2_q        <= v2_d;
         v3_q        <= v3_d;
         v4_q        <= v4_d;
         a1_q        <= a1_d;
         b1_q        <= b1_d;
         pp_ll_q     <= pp_ll_d;
         pp_lh_q     <= pp_lh_d;
         pp_hl_q     <= pp_hl_d;
         pp_hh_q     <= pp_hh_d;
         prod_q      <= prod_d;
         t1_q        <= t1_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         idx_q       <= idx_d;
`ifdef TF_MUL_ONE_BYPASS_EN
         one1_q <= one1_d;  one2_q <= one2_d;  one3_q <= one3_d;  one4_q <= one4_d;
         raw1_q <= raw1_d;  raw2_q <= raw2_d;  raw3_q <= raw3_d;  raw4_q <= raw4_d;
`endif
      end
   end

   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign out_idx    = idx_q;
   assign frame_done = out_valid_q && (idx_q == {IDX_WIDTH{1'b1}});

endmodule

// File: tb/tb_tf_modmul_pipe.sv
// -----------------------------------------------------------------------------
// tb_tf_modmul_pipe
//
// Directed bench for tf_modmul_pipe. A table of {in_data, tf, expected} records
// with hand-computed products mod p is streamed through the pipe. Hand-written
// sequences then cover the stall, reset mid-flight and index wrap cases.
//
// A small latency/index model tracks what the output must show after every
// edge. The model is a 5-entry shift of {valid, expected} that moves only on
// enabled edges, plus a 4-bit index that advances when a valid beat leaves.
// Expected data always comes from the stimulus tables or from small integer
// products.
// -----------------------------------------------------------------------------
module tb_tf_modmul_pipe;

   logic        clk;
   logic        rst_n;
   logic        CEN;
   logic        in_valid;
   logic [63:0] in_data;
   logic [63:0] tf;
   logic        out_valid;
   logic [63:0] out_data;
   logic [3:0]  out_idx;
   logic        frame_done;

   tf_modmul_pipe #(.P_WIDTH(64), .IDX_WIDTH(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .CEN        (CEN),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .tf         (tf),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_idx    (out_idx),
      .frame_done (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] exp;
   } vec_t;

   localparam int NVEC = 14;
   vec_t vecs [NVEC];

   int n_tests = 0;
   int n_fail  = 0;

   // expected-output model
   logic        mv [5];
   logic [63:0] me [5];
   logic [3:0]  midx;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic model_clear();
      for (int k = 0; k < 5; k++) begin
         mv[k] = 1'b0;
         me[k] = '0;
      end
      midx = '0;
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, ".out_valid"}, {63'd0, out_valid}, {63'd0, mv[4]});
      if (mv[4]) chk({tag, ".out_data"}, out_data, me[4]);
      chk({tag, ".out_idx"}, {60'd0, out_idx}, {60'd0, midx});
      chk({tag, ".frame_done"}, {63'd0, frame_done},
          {63'd0, (mv[4] && (midx == 4'd15))});
   endtask

   // Called at a negedge. Drives one cycle, updates the model on the edge and
   // checks the outputs on the following negedge.
   task automatic step(input string tag, input logic cen, input logic v,
                       input logic [63:0] a, input logic [63:0] b, input logic [63:0] e);
      CEN      = cen;
      in_valid = v;
      in_data  = a;
      tf       = b;
      @(posedge clk);
      if (!cen) begin
         if (mv[4]) midx = midx + 4'd1;
         for (int k = 4; k > 0; k--) begin
            mv[k] = mv[k-1];
            me[k] = me[k-1];
         end
         mv[0] = v;
         me[0] = e;
      end
      @(negedge clk);
      check_outputs(tag);
      $display("[TB] %s cen=%0b v=%0b a=%h b=%h -> ov=%0b od=%h idx=%0d fd=%0b",
               tag, cen, v, a, b, out_valid, out_data, out_idx, frame_done);
   endtask

   task automatic drain(input string tag);
      for (int k = 0; k < 5; k++) step(tag, 1'b0, 1'b0, 64'd0, 64'd0, 64'd0);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, ".out_valid"},  {63'd0, out_valid},  64'd0);
      chk({tag, ".out_data"},   out_data,            64'd0);
      chk({tag, ".out_idx"},    {60'd0, out_idx},    64'd0);
      chk({tag, ".frame_done"}, {63'd0, frame_done}, 64'd0);
   endtask

   initial begin
      logic [63:0] a_v, b_v;

      vecs[0]  = '{64'h0123456789ABCDEF, 64'd1,                 64'h0123456789ABCDEF};
      vecs[1]  = '{64'h0000000100000000, 64'h0000000100000000, 64'h00000000FFFFFFFF};
      vecs[2]  = '{64'hFFFFFFFF00000000, 64'hFFFFFFFF00000000, 64'h0000000000000001};
      vecs[3]  = '{64'hFFFFFFFFFFFFFFFF, 64'd1,                 64'h00000000FFFFFFFE};
      vecs[4]  = '{64'd0,                64'h381d997f2d35d682, 64'd0};
      vecs[5]  = '{64'd2,                64'd3,                 64'd6};
      vecs[6]  = '{64'hFFFFFFFF00000001, 64'd5,                 64'd0};
      vecs[7]  = '{64'h8000000000000000, 64'd2,                 64'h00000000FFFFFFFF};
      vecs[8]  = '{64'h0000000100000000, 64'h8000000000000000, 64'h7FFFFFFF80000000};
      vecs[9]  = '{64'h0001000000000000, 64'h0001000000000000, 64'hFFFFFFFF00000000};
      vecs[10] = '{64'hFFFFFFFF00000000, 64'd2,                 64'hFFFFFFFEFFFFFFFF};
      vecs[11] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFC00000004};
      vecs[12] = '{64'hFFFFFFFF00000006, 64'd1,                 64'd5};
      vecs[13] = '{64'd3,                64'hFFFFFFFF00000000, 64'hFFFFFFFEFFFFFFFE};

      // ---------------- reset state ----------------
      rst_n    = 1'b1;
      CEN      = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      tf       = '0;
      model_clear();
      repeat (2) @(negedge clk);
      check_zero("reset");
      rst_n = 1'b0;

      // ---------------- table vectors, back to back ----------------
      for (int i = 0; i < NVEC; i++) begin
         step($sformatf("vec%0d", i), 1'b0, 1'b1, vecs[i].a, vecs[i].b, vecs[i].exp);
      end
      drain("vec_drain");

      // ---------------- stall mid-stream ----------------
      // Inputs presented while CEN = 1 must be ignored.
      for (int i = 0; i < 6; i++) begin
         a_v = 64'd10 + 64'(i);
         b_v = 64'd1000 + 64'(i);
         step("stall_pre", 1'b0, 1'b1, a_v, b_v, a_v * b_v);
      end
      for (int i = 0; i < 5; i++) begin
         step("stall_hold", 1'b1, 1'b1, 64'hDEAD, 64'd1, 64'd0);
      end
      for (int i = 6; i < 8; i++) begin
         a_v = 64'd10 + 64'(i);
         b_v = 64'd1000 + 64'(i);
         step("stall_post", 1'b0, 1'b1, a_v, b_v, a_v * b_v);
      end
      drain("stall_drain");

      // ---------------- reset mid-flight ----------------
      for (int i = 0; i < 5; i++) begin
         a_v = 64'd7 + 64'(i);
         step("rst_pre", 1'b0, 1'b1, a_v, 64'd9, a_v * 64'd9);
      end
      #2 rst_n = 1'b1;
      #1 check_zero("rst_async");
      model_clear();
      @(negedge clk);
      rst_n = 1'b0;
      for (int i = 0; i < 5; i++) step("rst_idle", 1'b0, 1'b0, 64'd0, 64'd0, 64'd0);

      // ---------------- index wrap with bubbles ----------------
      for (int i = 0; i < 22; i++) begin
         if (i == 5 || i == 12) begin
            step("wrap_bubble", 1'b0, 1'b0, 64'd0, 64'd0, 64'd0);
         end else begin
            a_v = 64'd3 + 64'(i);
            b_v = (i % 5 == 0) ? 64'd1 : 64'd17 + 64'(i);
            step("wrap", 1'b0, 1'b1, a_v, b_v, a_v * b_v);
         end
      end
      drain("wrap_drain");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
